// File: rtl/io_map_pkg.sv
// ---------------------------------------------------------------------------
// io_map_pkg
//   Shared IO address map for the memory-mapped IO port. The memory stage and
//   the firmware headers take device positions from here, so the decode in
//   io_responder and software stay in step.
//
//   Contents:
//     DEV_*               one-hot select bit index of each device within the
//                         word-address field (select bit k = byte addr bit 2+k)
//     IO_BASE_BIT         byte-address bit that routes an access to the IO port
//     UART_STAT_BUSY_BIT  bit position of "busy" in the UART status word
//     calc_baud_div()     clock cycles per UART bit, truncated
//     uart_state_e        transmitter FSM states
// ---------------------------------------------------------------------------
package io_map_pkg;

    localparam int NUM_DEVS      = 5;
    localparam int DEV_LEDS      = 0;
    localparam int DEV_UART_DATA = 1;
    localparam int DEV_UART_STAT = 2;
    localparam int DEV_CYC_LO    = 3;
    localparam int DEV_CYC_HI    = 4;

    // Lowest byte-address bit used for device select (word addressing).
    localparam int SEL_LSB = 2;

    localparam int IO_BASE_BIT        = 22;
    localparam int UART_STAT_BUSY_BIT = 0;

    function automatic int calc_baud_div(input int clk_freq_hz, input int baud);
        return clk_freq_hz / baud;
    endfunction

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/io_responder_uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
//   8N1 transmitter, LSB first. One bit period is BAUD_DIV clock cycles, so a
//   complete frame (start + 8 data + stop) occupies 10*BAUD_DIV cycles.
//
//   Ports:
//     clk_i     core clock
//     reset_i   synchronous active-high reset; aborts any frame in flight
//     start_i   request to send data_i; only honoured while idle
//     data_i    byte to send
//     busy_o    registered, high from the cycle after an accepted start until
//               the last stop-bit cycle inclusive
//     tx_o      registered serial line, idles high
// ---------------------------------------------------------------------------
module uart_tx
    import io_map_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       busy_o,
    output logic       tx_o
);

    // A one-cycle bit period still needs a 1-bit counter to exist.
    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD_DIV - 1);

    uart_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       shift_q;
    logic [2:0]       bit_q;
    logic             tx_q;
    logic             busy_q;

    // Outputs are registered alongside the state so that tx and busy change
    // on exactly the same edge as the state they describe.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= UART_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                UART_IDLE: begin
                    if (start_i) begin
                        state_q <= UART_START;
                        cnt_q   <= '0;
                        shift_q <= data_i;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                UART_START: begin
                    if (cnt_q == CNT_MAX) begin
                        state_q <= UART_DATA;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                UART_DATA: begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            state_q <= UART_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            shift_q <= {1'b0, shift_q[7:1]};
                            // Next bit is what shift_q[0] becomes after the shift.
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                UART_STOP: begin
                    if (cnt_q == CNT_MAX) begin
                        state_q <= UART_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= UART_IDLE;
                    cnt_q   <= '0;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign tx_o   = tx_q;

endmodule

// File: rtl/io_responder.sv
// ---------------------------------------------------------------------------
// io_responder
//   Far end of the memory stage's IO port. Address bits [6:2] are a one-hot
//   device select (all other address bits ignored, so the map mirrors). Reads
//   are combinational; writes commit on the edge ending the strobe cycle.
//
//   Devices: LED register (RW), UART data (W), UART status (R, bit0 busy),
//            64-bit free-running cycle counter low/high words (R).
//
//   Ports:
//     clk_i          core clock
//     reset_i        synchronous active-high reset
//     IO_memAddr_i   byte address of the access
//     IO_memWData_i  store data, full word
//     IO_memWr_i     single-cycle write strobe
//     IO_memRData_o  read data for IO_memAddr_i, same cycle
//     leds_o         LED register
//     uart_tx_o      UART serial line, idles high
// ---------------------------------------------------------------------------
module io_responder
    import io_map_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 115200,
    parameter int NUM_LEDS    = 8
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [31:0]         IO_memAddr_i,
    input  logic [31:0]         IO_memWData_i,
    input  logic                IO_memWr_i,
    output logic [31:0]         IO_memRData_o,
    output logic [NUM_LEDS-1:0] leds_o,
    output logic                uart_tx_o
);

    localparam int BAUD_DIV = calc_baud_div(CLK_FREQ_HZ, BAUD);

    logic [NUM_DEVS-1:0] sel;
    logic [NUM_LEDS-1:0] leds_q;
    logic [63:0]         cyc_q;
    logic                uart_busy;
    logic                uart_start;
    logic                unused_ok;

    assign sel = IO_memAddr_i[SEL_LSB +: NUM_DEVS];

    // Address bits outside the select field are intentionally don't-care.
    assign unused_ok = ^{IO_memAddr_i[31:SEL_LSB+NUM_DEVS], IO_memAddr_i[SEL_LSB-1:0],
                         IO_memWData_i};

    // Writes while the transmitter is busy are simply dropped.
    assign uart_start = IO_memWr_i & sel[DEV_UART_DATA] & ~uart_busy;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            leds_q <= '0;
            cyc_q  <= '0;
        end else begin
            if (IO_memWr_i && sel[DEV_LEDS])
                leds_q <= IO_memWData_i[NUM_LEDS-1:0];
            cyc_q <= cyc_q + 64'd1;
        end
    end

    uart_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart_tx (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .start_i (uart_start),
        .data_i  (IO_memWData_i[7:0]),
        .busy_o  (uart_busy),
        .tx_o    (uart_tx_o)
    );

    // Multiple select bits OR their devices together; no select reads 0.
    always_comb begin
        IO_memRData_o = '0;
        if (sel[DEV_LEDS])
            IO_memRData_o = IO_memRData_o | 32'(leds_q);
        if (sel[DEV_UART_STAT])
            IO_memRData_o[UART_STAT_BUSY_BIT] = IO_memRData_o[UART_STAT_BUSY_BIT] | uart_busy;
        if (sel[DEV_CYC_LO])
            IO_memRData_o = IO_memRData_o | cyc_q[31:0];
        if (sel[DEV_CYC_HI])
            IO_memRData_o = IO_memRData_o | cyc_q[63:32];
    end

    assign leds_o = leds_q;

endmodule

// File: tb/tb_io_responder.sv
// ---------------------------------------------------------------------------
// tb_io_responder
//   Randomized and directed stimulus against a cycle-level reference model of
//   the IO map. The stimulus side pushes expected values into a queue; the
//   monitor pops and compares on the falling edge of each cycle.
// ---------------------------------------------------------------------------
module tb_io_responder;

    localparam int BD = 4;   // 400 Hz / 100 baud

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        wr = 1'b0;
    logic [31:0] rdata;
    logic [7:0]  leds;
    logic        tx;

    io_responder #(
        .CLK_FREQ_HZ (400),
        .BAUD        (100),
        .NUM_LEDS    (8)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .IO_memAddr_i  (addr),
        .IO_memWData_i (wdata),
        .IO_memWr_i    (wr),
        .IO_memRData_o (rdata),
        .leds_o        (leds),
        .uart_tx_o     (tx)
    );

    always #5 clk = ~clk;

    typedef enum {K_RD, K_TX, K_LED} kind_e;
    typedef struct {
        kind_e       k;
        logic [31:0] exp;
        string       nm;
    } chk_t;

    chk_t q[$];
    int   nchk = 0;
    int   npass = 0;

    // ---------------- reference model (state of the current cycle) --------
    logic [7:0]  leds_m;
    logic [63:0] cyc_m;
    bit          txq[$];   // expected line level for each upcoming cycle

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        logic [31:0] r;
        r = 32'd0;
        if (a[2]) r = r | {24'd0, leds_m};
        if (a[4]) r = r | {31'd0, txq.size() != 0};
        if (a[5]) r = r | cyc_m[31:0];
        if (a[6]) r = r | cyc_m[63:32];
        return r;
    endfunction

    task automatic step(input logic rst, input logic [31:0] a, input logic [31:0] d,
                        input logic w, input bit crd, input bit ctx, input bit cled,
                        input string nm);
        bit busy;
        @(posedge clk);
        #1;
        reset_i = rst;
        addr    = a;
        wdata   = d;
        wr      = w;
        if (crd)  q.push_back('{K_RD, rd_model(a), {nm, "_rd"}});
        if (ctx)  q.push_back('{K_TX, {31'd0, (txq.size() != 0) ? txq[0] : 1'b1}, {nm, "_tx"}});
        if (cled) q.push_back('{K_LED, {24'd0, leds_m}, {nm, "_led"}});
        // advance the model across the edge that ends this cycle
        if (rst) begin
            leds_m = '0;
            cyc_m  = '0;
            txq.delete();
        end else begin
            busy = (txq.size() != 0);
            if (busy) void'(txq.pop_front());
            if (w && a[2]) leds_m = d[7:0];
            if (w && a[3] && !busy) begin
                for (int b = 0; b < 10; b++) begin
                    bit lvl;
                    lvl = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : d[b-1];
                    for (int r = 0; r < BD; r++) txq.push_back(lvl);
                end
            end
            cyc_m = cyc_m + 64'd1;
        end
    endtask

    // ---------------- monitor ----------------
    chk_t mc;
    logic [31:0] act;
    always @(negedge clk) begin
        while (q.size() > 0) begin
            mc = q.pop_front();
            case (mc.k)
                K_RD:    act = rdata;
                K_TX:    act = {31'd0, tx};
                default: act = {24'd0, leds};
            endcase
            nchk++;
            if (act === mc.exp) npass++;
            else $display("FAIL %s: got %h expected %h", mc.nm, act, mc.exp);
        end
    end

    localparam logic [31:0] A_LED  = 32'h0040_0004;
    localparam logic [31:0] A_UD   = 32'h0040_0008;
    localparam logic [31:0] A_ST   = 32'h0040_0010;
    localparam logic [31:0] A_CLO  = 32'h0040_0020;
    localparam logic [31:0] A_CHI  = 32'h0040_0040;

    initial begin
        leds_m = '0;
        cyc_m  = '0;

        // reset held three cycles; DUT state unknown before, so no checks
        repeat (3) step(1, 0, 0, 0, 0, 0, 0, "rst");
        step(0, A_CLO, 0, 0, 1, 1, 1, "rst_cyc0");
        step(0, A_ST,  0, 0, 1, 1, 1, "rst_stat");
        repeat (3) step(0, 0, 0, 0, 0, 1, 0, "rst_idle");
        step(0, A_CLO, 0, 0, 1, 1, 1, "rst_cyc5");

        // LEDs: full-word write truncated; unselected write ignored
        step(0, A_LED, 32'hFFFF_FFA5, 1, 1, 0, 1, "led_wr");
        step(0, A_LED, 0, 0, 1, 0, 1, "led_rd");
        step(0, 32'h0040_0000, 32'h3C, 1, 1, 0, 1, "led_nosel");
        step(0, A_LED, 0, 0, 1, 0, 1, "led_keep");

        // UART frame of 0x53, status polled throughout
        step(0, A_UD, 32'h0000_0153, 1, 1, 1, 0, "uart_wr");
        for (int i = 0; i < 41; i++) step(0, A_ST, 0, 0, 1, 1, 0, "uart_frame");

        // busy drop plus multi-select read during the frame
        step(0, A_LED, 32'h01, 1, 0, 1, 1, "led1");
        step(0, A_UD, 32'h41, 1, 1, 1, 0, "drop_wr1");
        step(0, 0, 0, 0, 0, 1, 0, "drop_gap");
        step(0, A_UD, 32'h42, 1, 1, 1, 0, "drop_wr2");
        step(0, 32'h0040_0014, 0, 0, 1, 1, 1, "multisel");
        for (int i = 0; i < 44; i++) step(0, A_ST, 0, 0, 1, 1, 0, "drop_frame");

        // reset in the middle of data bit 3, then a clean frame
        step(0, A_UD, 32'hA7, 1, 0, 1, 0, "mid_wr");
        for (int i = 0; i < 17; i++) step(0, A_ST, 0, 0, 1, 1, 0, "mid_frame");
        step(1, A_ST, 0, 0, 1, 1, 0, "mid_rst");
        step(0, A_ST, 0, 0, 1, 1, 1, "after_rst");
        step(0, A_UD, 32'h55, 1, 1, 1, 0, "x55_wr");
        for (int i = 0; i < 41; i++) step(0, A_ST, 0, 0, 1, 1, 0, "x55_frame");

        // counter wrap: load all-ones between edges, observe the wrap
        step(0, 0, 0, 0, 0, 1, 0, "wrap_prep");
        #1 force dut.cyc_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1 release dut.cyc_q;
        cyc_m = '0;
        step(0, A_CHI, 0, 0, 1, 0, 0, "wrap_hi");
        step(0, 0, 0, 0, 0, 1, 0, "wrap_prep2");
        #1 force dut.cyc_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1 release dut.cyc_q;
        cyc_m = '0;
        step(0, A_CLO, 0, 0, 1, 0, 0, "wrap_lo");
        step(0, A_CHI, 0, 0, 1, 0, 0, "wrap_hi1");

        // randomized traffic, mirrored upper address bits
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            logic        w;
            a = $urandom;
            a[6:2] = 5'($urandom_range(0, 31));
            d = $urandom;
            w = ($urandom_range(0, 5) == 0);
            step(0, a, d, w, 1, 1, 1, "rand");
        end

        step(0, 0, 0, 0, 0, 0, 0, "end");
        repeat (3) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            nchk++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
